// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter
//   Turns a binary word into ASCII hex characters for the UART transmitter.
//   It can add a "0x" prefix and a CR/LF terminator, so each word prints as
//   one readable terminal line. The output is a registered valid/ready byte
//   stream with no bubbles inside a message.
//
// Parameters
//   NIBBLES   : hex digits per word (1..16); in_data is 4*NIBBLES bits wide
//   UPPERCASE : 1 = 'A'-'F', 0 = 'a'-'f'
//   PREFIX_0X : 1 = emit "0x" before the digits
//   ADD_CRLF  : 1 = emit CR, LF after the digits
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_data   : word to print, MSB nibble first
//   in_valid  : in_data valid
//   in_ready  : formatter idle and able to accept a word
//   out_data  : ASCII character to the UART TX stage
//   out_valid : out_data valid
//   out_ready : downstream accepts out_data
//   busy      : message in progress
module uart_hex_formatter #(
  parameter int NIBBLES   = 8,
  parameter int UPPERCASE = 1,
  parameter int PREFIX_0X = 0,
  parameter int ADD_CRLF  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  // Each state names the character currently held on out_data.
  typedef enum logic [2:0] {
    IDLE,
    P0,
    PX,
    HEX,
    CR,
    LF
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    word, word_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [7:0]      data_nx;
  logic            valid_nx;
  logic            armed;
  logic            xfer;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
    return ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [3:0] nibble_at(input logic [W-1:0] w,
                                           input logic [IW-1:0] i);
    logic [3:0] nib;
    nib = 4'h0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (i == IW'(k)) begin
        nib = w[4*k +: 4];
      end
    end
    return nib;
  endfunction

  // armed stays low through reset and for the first edge after release,
  // so in_ready is low while rst_n is low.
  assign in_ready = armed && (state == IDLE);
  assign busy     = (state != IDLE);
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      word      <= word_nx;
      idx       <= idx_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      armed     <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    word_nx  = word;
    idx_nx   = idx;
    data_nx  = out_data;
    valid_nx = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          word_nx  = in_data;
          idx_nx   = LAST_IDX;
          valid_nx = 1'b1;
          if (PREFIX_0X != 0) begin
            state_nx = P0;
            data_nx  = 8'h30;
          end else begin
            // First digit comes straight from in_data: word is only
            // loaded on this same edge.
            state_nx = HEX;
            data_nx  = hex_char(nibble_at(in_data, LAST_IDX));
          end
        end
      end
      P0: begin
        if (xfer) begin
          state_nx = PX;
          data_nx  = 8'h78;
        end
      end
      PX: begin
        if (xfer) begin
          state_nx = HEX;
          idx_nx   = LAST_IDX;
          data_nx  = hex_char(nibble_at(word, LAST_IDX));
        end
      end
      HEX: begin
        if (xfer) begin
          if (idx == '0) begin
            if (ADD_CRLF != 0) begin
              state_nx = CR;
              data_nx  = 8'h0D;
            end else begin
              state_nx = IDLE;
              valid_nx = 1'b0;
            end
          end else begin
            idx_nx  = idx - IW'(1);
            data_nx = hex_char(nibble_at(word, idx - IW'(1)));
          end
        end
      end
      CR: begin
        if (xfer) begin
          state_nx = LF;
          data_nx  = 8'h0A;
        end
      end
      LF: begin
        if (xfer) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_hex_formatter.sv
module tb_uart_hex_formatter;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_s  [3];
  logic        out_valid_s [3];
  logic        busy_s      [3];
  logic [7:0]  out_data_s  [3];

  // Three configurations: A = 8 digits upper + CRLF, B = 8 digits lower
  // with "0x" + CRLF, C = 2 digits upper, no CRLF. All share the inputs.
  uart_hex_formatter #(.NIBBLES(8), .UPPERCASE(1), .PREFIX_0X(0), .ADD_CRLF(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s[0]), .out_data(out_data_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready), .busy(busy_s[0]));

  uart_hex_formatter #(.NIBBLES(8), .UPPERCASE(0), .PREFIX_0X(1), .ADD_CRLF(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s[1]), .out_data(out_data_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready), .busy(busy_s[1]));

  uart_hex_formatter #(.NIBBLES(2), .UPPERCASE(1), .PREFIX_0X(0), .ADD_CRLF(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(in_ready_s[2]), .out_data(out_data_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready), .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int p_n  [3] = '{8, 8, 2};
  int p_uc [3] = '{1, 0, 1};
  int p_pf [3] = '{0, 1, 0};
  int p_cr [3] = '{1, 1, 0};

  // Reference model: the whole message for the current word as a list of
  // characters, plus a read position.
  logic [7:0] mbuf [3][16];
  int         mlen [3];
  int         mpos [3];
  logic       armed;

  logic [7:0] rx  [3][64];
  int         rxn [3];

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] word;
    string       ea;
    string       eb;
    string       ec;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic load_msg(input int d, input logic [31:0] w);
    int p;
    int nib;
    p = 0;
    if (p_pf[d] != 0) begin
      mbuf[d][p] = 8'h30; p = p + 1;
      mbuf[d][p] = 8'h78; p = p + 1;
    end
    for (int k = 0; k < p_n[d]; k++) begin
      nib = int'((w >> (4 * (p_n[d] - 1 - k))) & 32'hF);
      if (nib < 10) mbuf[d][p] = 8'(48 + nib);
      else if (p_uc[d] != 0) mbuf[d][p] = 8'(65 + nib - 10);
      else mbuf[d][p] = 8'(97 + nib - 10);
      p = p + 1;
    end
    if (p_cr[d] != 0) begin
      mbuf[d][p] = 8'h0D; p = p + 1;
      mbuf[d][p] = 8'h0A; p = p + 1;
    end
    mlen[d] = p;
    mpos[d] = 0;
  endtask

  function automatic bit all_idle();
    return (mpos[0] >= mlen[0]) && (mpos[1] >= mlen[1]) && (mpos[2] >= mlen[2]);
  endfunction

  // Called just after a falling edge: check outputs against the model,
  // drive inputs for the next rising edge, advance the model, wait.
  task automatic step(input logic v, input logic [31:0] data, input logic rdy);
    bit ev;
    for (int d = 0; d < 3; d++) begin
      ev = (mpos[d] < mlen[d]);
      chk("out_valid", d, out_valid_s[d], ev);
      if (ev) chk("out_data", d, out_data_s[d], mbuf[d][mpos[d]]);
      chk("in_ready", d, in_ready_s[d], armed && !ev);
      chk("busy", d, busy_s[d], ev);
    end
    in_valid  = v;
    in_data   = data;
    out_ready = rdy;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        mlen[d] = 0;
        mpos[d] = 0;
      end else if (armed && (mpos[d] >= mlen[d]) && v) begin
        load_msg(d, data);
      end else if ((mpos[d] < mlen[d]) && rdy) begin
        if (rxn[d] < 64) rx[d][rxn[d]] = out_data_s[d];
        rxn[d] = rxn[d] + 1;
        mpos[d] = mpos[d] + 1;
      end
    end
    armed = rst_n;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!all_idle() && n < 200) begin
      step(1'b0, $urandom, 1'b1);
      n++;
    end
    vectors++;
    if (!all_idle()) begin
      miscompares++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic clear_rx();
    for (int d = 0; d < 3; d++) rxn[d] = 0;
  endtask

  task automatic cmp_rx(input int d, input string exp, input bit prefix_only);
    if (!prefix_only) chk("rx_len", d, rxn[d], exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (i < rxn[d] && i < 64) chk("rx_byte", d, rx[d][i], exp[i]);
      else chk("rx_missing", d, 32'hFFFF_FFFF, exp[i]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    clear_rx();
    step(1'b1, v.word, 1'b1);
    repeat (14) step(1'b0, $urandom, 1'b1);
    cmp_rx(0, v.ea, 1'b0);
    cmp_rx(1, v.eb, 1'b0);
    cmp_rx(2, v.ec, 1'b0);
  endtask

  task automatic set_vec(input int i, input logic [31:0] w, input string a,
                         input string b, input string c);
    tbl[i].word = w;
    tbl[i].ea   = a;
    tbl[i].eb   = b;
    tbl[i].ec   = c;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    armed       = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mlen[d] = 0;
      mpos[d] = 0;
      rxn[d]  = 0;
    end

    set_vec(0, 32'hDEADBEEF, "DEADBEEF\015\012", "0xdeadbeef\015\012", "EF");
    set_vec(1, 32'h0000000A, "0000000A\015\012", "0x0000000a\015\012", "0A");
    set_vec(2, 32'h12345678, "12345678\015\012", "0x12345678\015\012", "78");
    set_vec(3, 32'h000000A5, "000000A5\015\012", "0x000000a5\015\012", "A5");
    set_vec(4, 32'hFFFFFFFF, "FFFFFFFF\015\012", "0xffffffff\015\012", "FF");
    set_vec(5, 32'h00000000, "00000000\015\012", "0x00000000\015\012", "00");
    set_vec(6, 32'hCAFEF00D, "CAFEF00D\015\012", "0xcafef00d\015\012", "0D");

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", d, out_valid_s[d], 1'b0);
      chk("rst_out_data", d, out_data_s[d], 8'h00);
      chk("rst_busy", d, busy_s[d], 1'b0);
      chk("rst_in_ready", d, in_ready_s[d], 1'b0);
    end
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);

    // Table of words with expected character strings
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Backpressure: hold '1' for 5 cycles, then random ready
    wait_idle();
    clear_rx();
    step(1'b1, 32'h12345678, 1'b1);
    repeat (5) step(1'b0, $urandom, 1'b0);
    repeat (60) step(1'b0, $urandom, 1'($urandom_range(0, 1)));
    wait_idle();
    cmp_rx(0, tbl[2].ea, 1'b0);
    cmp_rx(1, tbl[2].eb, 1'b0);
    cmp_rx(2, tbl[2].ec, 1'b0);

    // Back-to-back with in_valid held; in_data changes right after accept
    wait_idle();
    clear_rx();
    step(1'b1, 32'h00000001, 1'b1);
    repeat (15) step(1'b1, 32'hFFFFFFFF, 1'b1);
    repeat (30) step(1'b0, $urandom, 1'b1);
    wait_idle();
    cmp_rx(0, "00000001\015\012FFFFFFFF\015\012", 1'b0);
    cmp_rx(1, "0x00000001\015\0120xffffffff\015\012", 1'b0);
    cmp_rx(2, "01FF", 1'b1);

    // Reset in the middle of a message
    wait_idle();
    clear_rx();
    step(1'b1, 32'hCAFEF00D, 1'b1);
    repeat (3) step(1'b0, $urandom, 1'b1);
    cmp_rx(0, "CAF", 1'b0);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("midrst_out_valid", d, out_valid_s[d], 1'b0);
      chk("midrst_out_data", d, out_data_s[d], 8'h00);
      chk("midrst_busy", d, busy_s[d], 1'b0);
      chk("midrst_in_ready", d, in_ready_s[d], 1'b0);
      mlen[d] = 0;
      mpos[d] = 0;
    end
    armed = 1'b0;
    step(1'b0, $urandom, 1'b1);
    step(1'b0, $urandom, 1'b1);
    rst_n = 1'b1;
    step(1'b0, $urandom, 1'b1);
    step(1'b0, $urandom, 1'b1);
    run_vec(tbl[5]);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    wait_idle();
    step(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
